pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Parametrised pipeline-stage register for the 64-bit RISC-V core.
//   Generalises the fixed ID/EX latch: a valid/ready handshake, a 2-entry
//   skid buffer for back-pressure, synchronous flush with bubble insertion,
//   and a saturating stall counter.
//   Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Control bits and datapath bits are carried on separate buses so that a
//   bubble can force control to NOP.
// PARAMETERS
//   DATA_W       256    datapath payload width (PC, operands, imm, reg idx, funct)
//   CTRL_W       9      control payload width (Branch..RegWrite, ALUOp)
//   BUBBLE_CTRL  0      value driven on out_ctrl when out_valid=0
//   STAT_W       16     width of the stall counter
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high reset
//   flush        in   1       synchronous kill of all held entries
//   in_valid     in   1       upstream presents in_ctrl/in_data
//   in_ready     out  1       stage can accept this cycle
//   in_ctrl      in   CTRL_W  control payload
//   in_data      in   DATA_W  datapath payload
//   out_valid    out  1       main entry valid
//   out_ready    in   1       downstream accepts this cycle
//   out_ctrl     out  CTRL_W  main-entry control, or BUBBLE_CTRL when invalid
//   out_data     out  DATA_W  main-entry data; unchanged while invalid
//   stall_cnt    out  STAT_W  cycles with out_valid & ~out_ready; saturates
// BEHAVIOUR
//   - Storage: main register (M) drives the outputs; skid register (S).
//     in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Reset (async): M, S valid=0; ctrl and data regs=0; stall_cnt=0.
//     Consequently out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, in_ready=1.
//   - in_ready = ~S.valid, driven from a register with no combinational path
//     from out_ready.
//   - Latency: 1 cycle from in_fire to out_valid when empty.
//     Throughput: 1 per cycle while out_ready=1.
//   - States (from {M.valid, S.valid}):
//       EMPTY  M.v=0, S.v=0
//       ONE    M.v=1, S.v=0
//       FULL   M.v=1, S.v=1
//   - Transitions:
//       EMPTY: in_fire -> ONE, M<=in. Otherwise stay in EMPTY.
//       ONE:   in_fire & out_fire -> ONE, M<=in.
//              in_fire & ~out_ready -> FULL, S<=in.
//              ~in_fire & out_fire -> EMPTY.
//              Otherwise hold.
//       FULL:  out_fire -> ONE, M<=S, S.v<=0.
//              Otherwise hold. No in_fire is possible because in_ready=0.
//   - Payload ordering is strictly FIFO. No entry is dropped or duplicated
//     except by flush.
//   - flush: has priority over all transitions. Next state is EMPTY and any
//     same-cycle in_fire is discarded. out_fire in the flush cycle is still
//     counted as consumed downstream. Data registers are not cleared.
//     in_ready=1 on the following cycle.
//   - stall_cnt: +1 on each cycle with out_valid & ~out_ready, including
//     flush cycles. Holds at 2^STAT_W-1. Cleared only by reset.
//   - reset mid-transfer: all entries lost immediately; no output glitch
//     beyond the async clear.
// TESTING
//   1. Reset release, in_valid=1, ctrl=9'h1A5, data=A, out_ready=1
//      -> next cycle out_valid=1, out_ctrl=9'h1A5, out_data=A.
//   2. Stream of 8 words with out_ready=1 -> one word out per cycle, in
//      order, in_ready stays 1.
//   3. out_ready=0 with 2 words sent -> FULL, in_ready=0, stall_cnt ramps
//      1,2,3. Then out_ready=1 -> words 1 and 2 out in order, in_ready=1
//      after the first pop.
//   4. In FULL, pulse flush with in_valid=1 -> next cycle out_valid=0,
//      out_ctrl=BUBBLE_CTRL, in_ready=1; the flushed-cycle input never
//      appears.
//   5. STAT_W=4 with out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
//   6. Assert reset asynchronously mid-stream -> out_valid=0 and
//      stall_cnt=0 before the next edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush (bubble insertion) and a saturating stall counter.
module pipe_stage_skid #(
    parameter int                DATA_W      = 256,
    parameter int                CTRL_W      = 9,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [STAT_W-1:0] stall_cnt
);

    // Encoding is {M.valid, S.valid}, so both valid bits come straight from the register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t            state, state_nx;
    logic              in_fire, out_fire;
    logic              load_m, load_s, m_from_s;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nx;
    end

    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        state_nx = state;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx = ONE;
                    load_m   = 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_m = 1'b1;
                    end else if (in_fire) begin
                        state_nx = FULL;
                        load_s   = 1'b1;
                    end else if (out_fire) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: if (out_fire) begin
                    state_nx = ONE;
                    m_from_s = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // in_ready depends only on the state register, never on out_ready.
    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = (state != FULL);
        out_ctrl  = out_valid ? m_ctrl : BUBBLE_CTRL;
        out_data  = m_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else begin
            if (load_m) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
            end else if (m_from_s) begin
                m_ctrl <= s_ctrl;
                m_data <= s_data;
            end
            if (load_s) begin
                s_ctrl <= in_ctrl;
                s_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {STAT_W{1'b1}})
            stall_cnt <= stall_cnt + STAT_W'(1);
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized bench for pipe_stage_skid against a queue-based FIFO reference model.
module tb_pipe_stage_skid;

    localparam int DW = 256;
    localparam int CW = 9;
    localparam int OW = 1 + 1 + CW + DW + 16 + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, in_ready4, out_valid4;
    logic [CW-1:0] out_ctrl, out_ctrl4;
    logic [DW-1:0] out_data, out_data4;
    logic [15:0]   stall_cnt;
    logic [3:0]    stall4;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.STAT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
        .stall_cnt(stall4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        q[$];
    logic [DW-1:0] shown = '0;
    int            ms = 0;
    int            ms4 = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    wire [OW-1:0] dut_out = {out_valid, in_ready, out_ctrl, out_data, stall_cnt, stall4};

    // Expected observable outputs of the stage, derived from the FIFO occupancy.
    function automatic logic [OW-1:0] model_out();
        logic [CW-1:0] c;
        c = '0;
        if (q.size() > 0) c = q[0].ctrl;
        return {q.size() > 0, q.size() < 2, c, shown, 16'(ms), 4'(ms4)};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        q.delete();
        shown = '0;
        ms = 0;
        ms4 = 0;
    endtask

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic cycle();
        int   n;
        logic inf, outf;
        @(posedge clk);
        n    = q.size();
        inf  = in_valid && (n < 2);
        outf = (n > 0) && out_ready;
        if (n > 0 && !out_ready) begin
            if (ms != 65535) ms++;
            if (ms4 != 15) ms4++;
        end
        if (flush) q.delete();
        else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back('{in_ctrl, in_data});
        end
        if (q.size() > 0) shown = q[0].data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (dut_out !== {1'b0, 1'b1, 9'h0, 256'h0, 16'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset got %h want valid=0 ready=1 all zero", dut_out);
        end
    endtask

    task automatic test_first();
        logic [DW-1:0] a;
        a = rnd_data();
        in_valid = 1'b1; in_ctrl = 9'h1A5; in_data = a; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_ctrl, out_data} !== {1'b1, 9'h1A5, a}) begin
            n_fail++;
            $display("FAIL first got v=%b c=%h d=%h want v=1 c=1a5 d=%h", out_valid, out_ctrl, out_data, a);
        end
        cycle();
        n_cmp++;
        if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL first_drain got %h want %h", dut_out, model_out());
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 8);
            in_ctrl = CW'($urandom);
            in_data = rnd_data();
            cycle();
            n_cmp++;
            if (dut_out !== model_out() || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream[%0d] got %h want %h", i, dut_out, model_out());
            end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_ctrl = CW'($urandom);
            in_data = rnd_data();
            cycle();
            n_cmp++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL bp_fill[%0d] got %h want %h", i, dut_out, model_out());
            end
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready got %b want 0", in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL bp_drain[%0d] got %h want %h", i, dut_out, model_out());
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_ctrl = CW'($urandom); in_data = rnd_data();
            cycle();
        end
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 9'h155; in_data = rnd_data();
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_ctrl, in_ready} !== {1'b0, 9'h0, 1'b1} || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL flush got %h want %h", dut_out, model_out());
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (out_valid !== 1'b0 || dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL flush_after[%0d] got %h want %h", i, dut_out, model_out());
            end
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = CW'($urandom); in_data = rnd_data();
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        n_cmp++;
        if (stall4 !== 4'hF || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL saturate got stall4=%0d full=%h want stall4=15 full=%h", stall4, dut_out, model_out());
        end
        out_ready = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            in_ctrl = CW'($urandom);
            in_data = rnd_data();
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            cycle();
            n_cmp++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL random[%0d] got %h want %h", i, dut_out, model_out());
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = CW'($urandom); in_data = rnd_data();
        repeat (3) cycle();
        n_cmp++;
        if (out_valid !== 1'b1 || stall_cnt === 16'h0) begin
            n_fail++;
            $display("FAIL arst_pre got v=%b stall=%0d want v=1 stall>0", out_valid, stall_cnt);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_ctrl, stall_cnt, stall4, in_ready} !== {1'b0, 9'h0, 16'h0, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL arst got v=%b c=%h stall=%0d stall4=%0d rdy=%b want 0 0 0 0 1",
                     out_valid, out_ctrl, stall_cnt, stall4, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        model_reset();
        out_ready = 1'b1;
        cycle();
        n_cmp++;
        if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL arst_after got %h want %h", dut_out, model_out());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturate();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
